mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM-stage load/store engine; consumes the EX/MEM pipeline register outputs each cycle.
//  Performs loads/stores byte-serially over an 8-bit req/ack memory port.
//  Raises stallreq_o to the stall controller until the access completes.
//  Delivers the write-back triple (wd, wreg, wdata) to the MEM/WB register.
// PARAMETERS
//  ADDR_WIDTH  32  width of mem_addr_o; low ADDR_WIDTH bits of the effective address are used
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  wd_i         in   5   destination register from EX/MEM
//  wreg_i       in   1   register write enable from EX/MEM
//  wdata_i      in   32  ALU result; effective address for load/store ops
//  mmem_data_i  in   32  store data (rs2 value)
//  op_type_i    in   6   memory op code (encodings below)
//  mem_ack_i    in   1   byte transfer accepted this cycle; mem_din_i valid on read ack
//  mem_din_i    in   8   read byte
//  mem_req_o    out  1   byte transfer request
//  mem_wr_o     out  1   1=write, 0=read; valid while mem_req_o=1
//  mem_addr_o   out  AW  byte address
//  mem_dout_o   out  8   write byte
//  wd_o         out  5   to MEM/WB
//  wreg_o       out  1   to MEM/WB
//  wdata_o      out  32  to MEM/WB
//  stallreq_o   out  1   stall request to the stall controller (MEM stage)
// BEHAVIOUR
//  Op codes: 00 none, 01 LB, 02 LH, 03 LW, 04 LBU, 05 LHU, 06 SB, 07 SH, 08 SW; others = none.
//  Byte count N: B=1, H=2, W=4. Little-endian; byte k at address wdata_i+k (32-bit add, wraps).
//  Misaligned addresses are legal; no alignment check.
//  FSM: IDLE, XFER, DONE. Registers: state, cnt[1:0], buf[31:0].
//  IDLE: op none -> stay; outputs pass-through wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i.
//        op memory -> XFER next cycle, cnt=0; stallreq_o=1 combinationally in this cycle.
//  XFER: mem_req_o=1, mem_addr_o=wdata_i+cnt, mem_wr_o=1 for stores, mem_dout_o=mmem_data_i[8cnt+:8].
//        Request, address and data held stable until mem_ack_i. On ack: reads store mem_din_i
//        into buf[8cnt+:8]; cnt++; if cnt==N-1 -> DONE. stallreq_o=1 throughout.
//  Next byte request issued in the cycle after an ack (mem_req_o stays 1 across bytes).
//  DONE: one cycle; mem_req_o=0, stallreq_o=0; next state IDLE.
//        Loads: wreg_o=wreg_i, wd_o=wd_i, wdata_o = buf low N bytes sign-extended (LB/LH/LW)
//        or zero-extended (LBU/LHU). Stores: wreg_o=0, wd_o=0, wdata_o=0.
//  Inputs are held stable by the EX/MEM register while stallreq_o=1; DONE clears stall so
//  the next instruction enters on that edge; no op is executed twice.
//  Back-to-back memory ops: IDLE after DONE sees the new op and stalls again immediately.
//  Stores in IDLE/XFER drive wreg_o=0; loads drive wreg_o=0 until DONE (no early write-back).
//  Reset (any state, async): state=IDLE, cnt=0, buf=0, mem_req_o=0, mem_wr_o=0,
//   mem_addr_o=0, mem_dout_o=0; wd_o/wreg_o/wdata_o/stallreq_o = 0 while rst=1.
//  Reset mid-XFER abandons the access; partially written bytes are not rolled back.
//  Latency: memory op with ack every cycle = N+1 stall cycles + 1 DONE cycle.
// TESTING
//  1. op=00, wdata_i=0x1234, wd_i=5, wreg_i=1 -> same cycle wdata_o=0x1234, wd_o=5,
//     wreg_o=1, stallreq_o=0, mem_req_o=0.
//  2. LW addr 0x100, RAM bytes 78 56 34 12, ack each cycle -> addrs 0x100..0x103 on
//     successive cycles, DONE wdata_o=0x12345678, wreg_o=1, stallreq_o high for 5 cycles.
//  3. LB/LBU addr 0x7 byte 0x80 -> 0xFFFFFF80 / 0x00000080; LH/LHU at 0x3 with bytes 00 90
//     -> 0xFFFF9000 / 0x00009000 (misaligned accepted).
//  4. SH addr 0x20 data 0xAABBCCDD, ack delayed 3 cycles per byte -> writes 0xDD@0x20 then
//     0xCC@0x21, req/addr/dout stable while waiting, DONE wreg_o=0.
//  5. SW then LW back-to-back same address -> second op stalls right after DONE, reads back
//     the stored word; each op performed exactly once.
//  6. rst asserted mid-XFER of LW after 2 bytes -> mem_req_o=0 and stallreq_o=0 immediately
//     (async); after release op=00 passes through normally.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store engine. Moves loads and stores one byte at a
// time over an 8-bit req/ack port, stalls the pipeline while busy and hands the
// write-back triple to the MEM/WB register.
module mem_access #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [31:0]           mmem_data_i,
   input  logic [5:0]            op_type_i,
   input  logic                  mem_ack_i,
   input  logic [7:0]            mem_din_i,
   output logic                  mem_req_o,
   output logic                  mem_wr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [7:0]            mem_dout_o,
   output logic [4:0]            wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic                  stallreq_o
);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DONE
   } state_t;

   localparam logic [5:0] OP_LB  = 6'h01;
   localparam logic [5:0] OP_LH  = 6'h02;
   localparam logic [5:0] OP_LW  = 6'h03;
   localparam logic [5:0] OP_LBU = 6'h04;
   localparam logic [5:0] OP_LHU = 6'h05;
   localparam logic [5:0] OP_SB  = 6'h06;
   localparam logic [5:0] OP_SH  = 6'h07;
   localparam logic [5:0] OP_SW  = 6'h08;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;

   logic        isLoad;
   logic        isStore;
   logic        isMem;
   logic [1:0]  lastIdx;
   logic [31:0] effAddr;
   logic [31:0] loadResult;

   // Classify the op and find the index of its final byte (N-1).
   always_comb begin
      isLoad  = 1'b0;
      isStore = 1'b0;
      lastIdx = 2'd0;
      case (op_type_i)
         OP_LB, OP_LBU: begin
            isLoad  = 1'b1;
            lastIdx = 2'd0;
         end
         OP_LH, OP_LHU: begin
            isLoad  = 1'b1;
            lastIdx = 2'd1;
         end
         OP_LW: begin
            isLoad  = 1'b1;
            lastIdx = 2'd3;
         end
         OP_SB: begin
            isStore = 1'b1;
            lastIdx = 2'd0;
         end
         OP_SH: begin
            isStore = 1'b1;
            lastIdx = 2'd1;
         end
         OP_SW: begin
            isStore = 1'b1;
            lastIdx = 2'd3;
         end
         default: begin
            isLoad  = 1'b0;
            isStore = 1'b0;
         end
      endcase
   end

   assign isMem   = isLoad | isStore;
   assign effAddr = wdata_i + {30'd0, cnt_q};

   // Sign- or zero-extend the gathered bytes according to the load flavour.
   always_comb begin
      loadResult = buf_q;
      case (op_type_i)
         OP_LB:   loadResult = {{24{buf_q[7]}}, buf_q[7:0]};
         OP_LH:   loadResult = {{16{buf_q[15]}}, buf_q[15:0]};
         OP_LBU:  loadResult = {24'd0, buf_q[7:0]};
         OP_LHU:  loadResult = {16'd0, buf_q[15:0]};
         default: loadResult = buf_q;
      endcase
   end

   // State, byte counter and load assembly buffer; reset abandons any access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         buf_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state logic plus memory-port, stall and write-back outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      mem_req_o  = 1'b0;
      mem_wr_o   = 1'b0;
      mem_addr_o = '0;
      mem_dout_o = 8'd0;
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      stallreq_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (isMem) begin
               state_d    = XFER;
               cnt_d      = 2'd0;
               stallreq_o = 1'b1;
               wreg_o     = 1'b0;
            end
         end
         XFER: begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            mem_req_o  = 1'b1;
            mem_wr_o   = isStore;
            mem_addr_o = ADDR_WIDTH'(effAddr);
            mem_dout_o = mmem_data_i[{cnt_q, 3'b000} +: 8];
            if (mem_ack_i) begin
               if (isLoad) begin
                  buf_d[{cnt_q, 3'b000} +: 8] = mem_din_i;
               end
               if (cnt_q == lastIdx) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            if (isLoad) begin
               wdata_o = loadResult;
            end else begin
               wd_o    = 5'd0;
               wreg_o  = 1'b0;
               wdata_o = 32'd0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rst) begin
         wd_o       = 5'd0;
         wreg_o     = 1'b0;
         wdata_o    = 32'd0;
         stallreq_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a byte-wide RAM responder,
// a queue of expected byte transfers and a queue of expected write-back results.
module tb_mem_access;

   logic        clk;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] mmem_data_i;
   logic [5:0]  op_type_i;
   logic        mem_ack_i;
   logic [7:0]  mem_din_i;
   logic        mem_req_o;
   logic        mem_wr_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_dout_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  data;
   } xfer_t;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } wb_t;

   xfer_t      xferQ[$];
   wb_t        wbQ[$];
   logic [7:0] ram [0:4095];

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;
   int ackDelay   = 0;
   int ackCount   = 0;

   mem_access #(.ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .wdata_i     (wdata_i),
      .mmem_data_i (mmem_data_i),
      .op_type_i   (op_type_i),
      .mem_ack_i   (mem_ack_i),
      .mem_din_i   (mem_din_i),
      .mem_req_o   (mem_req_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_dout_o  (mem_dout_o),
      .wd_o        (wd_o),
      .wreg_o      (wreg_o),
      .wdata_o     (wdata_o),
      .stallreq_o  (stallreq_o)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence wedges somewhere unexpected.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checkCount++;
      assert (obs === expv) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // Drive the EX/MEM-side inputs.
   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [4:0] wd,
                                input logic wreg);
      op_type_i   = op;
      wdata_i     = addr;
      mmem_data_i = sdata;
      wd_i        = wd;
      wreg_i      = wreg;
   endtask

   // Issue one memory op, queue its expected transfers and result, then follow
   // it through the stall window and check the DONE cycle.
   task automatic runOp(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd,
                        input logic wreg, input int delay,
                        input logic [31:0] expLoad, input string tag);
      int    n;
      int    stalls;
      logic  isStore;
      xfer_t x;
      wb_t   w;
      wb_t   got;
      n       = (op == 6'h01 || op == 6'h04 || op == 6'h06) ? 1 :
                (op == 6'h02 || op == 6'h05 || op == 6'h07) ? 2 : 4;
      isStore = (op >= 6'h06 && op <= 6'h08);
      for (int k = 0; k < n; k++) begin
         x.wr   = isStore;
         x.addr = addr + 32'(k);
         x.data = sdata[8*k +: 8];
         xferQ.push_back(x);
      end
      w.wd    = isStore ? 5'd0 : wd;
      w.wreg  = isStore ? 1'b0 : wreg;
      w.wdata = isStore ? 32'd0 : expLoad;
      wbQ.push_back(w);
      @(negedge clk);
      ackDelay = delay;
      applyStimulus(op, addr, sdata, wd, wreg);
      #1;
      stalls = 0;
      while (stallreq_o === 1'b1 && stalls < 200) begin
         checkOutput({tag, "_noEarlyWb"}, 32'(wreg_o), 32'd0);
         stalls++;
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "_stallCycles"}, 32'(stalls), 32'(1 + n * (delay + 1)));
      checkOutput({tag, "_doneReq"}, 32'(mem_req_o), 32'd0);
      if (wbQ.size() == 0) begin
         checkOutput({tag, "_wbQueued"}, 32'(wbQ.size()), 32'd1);
      end else begin
         got = wbQ.pop_front();
         checkOutput({tag, "_wdata"}, wdata_o, got.wdata);
         checkOutput({tag, "_wreg"}, 32'(wreg_o), 32'(got.wreg));
         checkOutput({tag, "_wd"}, 32'(wd_o), 32'(got.wd));
      end
      checkOutput({tag, "_xfersLeft"}, 32'(xferQ.size()), 32'd0);
   endtask

   // Byte-wide RAM: acks after ackDelay waiting cycles, checks the request is
   // held stable while waiting, and matches each transfer against the queue.
   initial begin : responder
      logic [31:0] holdAddr;
      logic [7:0]  holdDout;
      logic        holdWr;
      int          waitCnt;
      xfer_t       expX;
      mem_ack_i = 1'b0;
      mem_din_i = 8'd0;
      waitCnt   = 0;
      holdAddr  = 32'd0;
      holdDout  = 8'd0;
      holdWr    = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         mem_ack_i = 1'b0;
         if (rst || !mem_req_o) begin
            waitCnt = 0;
         end else begin
            if (waitCnt == 0) begin
               holdAddr = mem_addr_o;
               holdDout = mem_dout_o;
               holdWr   = mem_wr_o;
            end else begin
               checkOutput("holdAddr", mem_addr_o, holdAddr);
               checkOutput("holdDout", 32'(mem_dout_o), 32'(holdDout));
               checkOutput("holdWr", 32'(mem_wr_o), 32'(holdWr));
            end
            if (waitCnt >= ackDelay) begin
               waitCnt   = 0;
               mem_ack_i = 1'b1;
               ackCount++;
               if (xferQ.size() == 0) begin
                  checkOutput("xferExpected", 32'(xferQ.size()), 32'd1);
               end else begin
                  expX = xferQ.pop_front();
                  checkOutput("xferAddr", mem_addr_o, expX.addr);
                  checkOutput("xferWr", 32'(mem_wr_o), 32'(expX.wr));
                  if (expX.wr) begin
                     checkOutput("xferDout", 32'(mem_dout_o), 32'(expX.data));
                  end
               end
               if (mem_wr_o) begin
                  ram[mem_addr_o[11:0]] = mem_dout_o;
               end else begin
                  mem_din_i = ram[mem_addr_o[11:0]];
               end
            end else begin
               waitCnt++;
            end
         end
      end
   end

   // Directed sequence.
   initial begin : mainSeq
      int ackBase;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'(i * 7 + 3);
      end
      rst = 1'b1;
      applyStimulus(6'h03, 32'hDEAD_BEEF, 32'h1111_2222, 5'h1F, 1'b1);

      // Reset holds every output low even with a load presented.
      #1;
      checkOutput("rst_wd", 32'(wd_o), 32'd0);
      checkOutput("rst_wreg", 32'(wreg_o), 32'd0);
      checkOutput("rst_wdata", wdata_o, 32'd0);
      checkOutput("rst_stall", 32'(stallreq_o), 32'd0);
      checkOutput("rst_req", 32'(mem_req_o), 32'd0);
      checkOutput("rst_wr", 32'(mem_wr_o), 32'd0);
      checkOutput("rst_addr", mem_addr_o, 32'd0);
      checkOutput("rst_dout", 32'(mem_dout_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      applyStimulus(6'h00, 32'd0, 32'd0, 5'd0, 1'b0);
      rst = 1'b0;

      // No-op passes straight through in the same cycle.
      @(negedge clk);
      applyStimulus(6'h00, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
      #1;
      checkOutput("pass_wdata", wdata_o, 32'h0000_1234);
      checkOutput("pass_wd", 32'(wd_o), 32'd5);
      checkOutput("pass_wreg", 32'(wreg_o), 32'd1);
      checkOutput("pass_stall", 32'(stallreq_o), 32'd0);
      checkOutput("pass_req", 32'(mem_req_o), 32'd0);

      // Word load, ack every cycle.
      ram[12'h100] = 8'h78;
      ram[12'h101] = 8'h56;
      ram[12'h102] = 8'h34;
      ram[12'h103] = 8'h12;
      runOp(6'h03, 32'h100, 32'd0, 5'd7, 1'b1, 0, 32'h1234_5678, "lw");

      // Byte and halfword loads, signed and unsigned, misaligned halfword.
      ram[12'h007] = 8'h80;
      ram[12'h003] = 8'h00;
      ram[12'h004] = 8'h90;
      runOp(6'h01, 32'h7, 32'd0, 5'd1, 1'b1, 0, 32'hFFFF_FF80, "lb");
      runOp(6'h04, 32'h7, 32'd0, 5'd2, 1'b1, 1, 32'h0000_0080, "lbu");
      runOp(6'h02, 32'h3, 32'd0, 5'd3, 1'b1, 0, 32'hFFFF_9000, "lh");
      runOp(6'h05, 32'h3, 32'd0, 5'd4, 1'b1, 2, 32'h0000_9000, "lhu");

      // Halfword store with slow acks; request must hold while waiting.
      runOp(6'h07, 32'h20, 32'hAABB_CCDD, 5'd9, 1'b1, 3, 32'd0, "sh");
      checkOutput("sh_ram20", 32'(ram[12'h020]), 32'h0000_00DD);
      checkOutput("sh_ram21", 32'(ram[12'h021]), 32'h0000_00CC);

      // Store then load of the same word, back to back.
      ackBase = ackCount;
      runOp(6'h08, 32'h40, 32'hCAFE_F00D, 5'd10, 1'b1, 1, 32'd0, "sw");
      runOp(6'h03, 32'h40, 32'd0, 5'd11, 1'b1, 0, 32'hCAFE_F00D, "lwBack");
      checkOutput("b2b_ackCount", 32'(ackCount - ackBase), 32'd8);
      @(negedge clk);
      applyStimulus(6'h00, 32'h40, 32'd0, 5'd0, 1'b0);
      #1;
      checkOutput("b2b_idleReq", 32'(mem_req_o), 32'd0);
      checkOutput("b2b_idleStall", 32'(stallreq_o), 32'd0);

      // Asynchronous reset in the middle of a word load.
      ackBase  = ackCount;
      ackDelay = 0;
      for (int k = 0; k < 4; k++) begin
         xferQ.push_back('{wr: 1'b0, addr: 32'h100 + 32'(k), data: 8'd0});
      end
      @(negedge clk);
      applyStimulus(6'h03, 32'h100, 32'd0, 5'd12, 1'b1);
      repeat (3) @(posedge clk);
      #3;
      checkOutput("mid_req", 32'(mem_req_o), 32'd1);
      checkOutput("mid_addr", mem_addr_o, 32'h102);
      checkOutput("mid_acks", 32'(ackCount - ackBase), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("arst_req", 32'(mem_req_o), 32'd0);
      checkOutput("arst_stall", 32'(stallreq_o), 32'd0);
      checkOutput("arst_wreg", 32'(wreg_o), 32'd0);
      xferQ.delete();
      @(negedge clk);
      applyStimulus(6'h00, 32'h0000_55AA, 32'd0, 5'd3, 1'b1);
      rst = 1'b0;
      #1;
      checkOutput("post_wdata", wdata_o, 32'h0000_55AA);
      checkOutput("post_wd", 32'(wd_o), 32'd3);
      checkOutput("post_wreg", 32'(wreg_o), 32'd1);
      checkOutput("post_stall", 32'(stallreq_o), 32'd0);
      repeat (2) begin
         @(negedge clk);
         #1;
         checkOutput("post_idleReq", 32'(mem_req_o), 32'd0);
      end
      checkOutput("post_acks", 32'(ackCount - ackBase), 32'd2);
      checkOutput("end_wbQueue", 32'(wbQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
